nroot: RTL

NROOT -- requirements
Module: nroot

---
 rtl/nroot_if.sv | 20 ++
 rtl/nroot.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/nroot_if.sv
// Start/ready bus for the integer n-th root unit; err and its modport entries exist only with NROOT_ERR_EN.
// Handshake: start is sampled only on an edge where ready=1. ready=1 means idle with out (and err) valid.
// ready=0 means busy: start, iny and inn are ignored and out holds the previous result.
interface nroot_if;
  logic        start;
  logic [15:0] iny;
  logic [7:0]  inn;
  logic        ready;
  logic [15:0] out;
  logic [1:0]  dbg_state;
`ifdef NROOT_ERR_EN
  logic        err;

  modport master (output start, iny, inn, input ready, out, err, dbg_state);
  modport slave  (input start, iny, inn, output ready, out, err, dbg_state);
`else
  modport master (output start, iny, inn, input ready, out, dbg_state);
  modport slave  (input start, iny, inn, output ready, out, dbg_state);
`endif
endinterface

// File: rtl/nroot.sv
// Integer n-th root: out = largest r with r^n <= y, built bit by bit, MSB first, with repeated 16x16 multiplies.
// Optional err output (err=1 when n=0) is enabled by defining NROOT_ERR_EN.
module nroot (
  input  logic   clk,
  input  logic   nrst,
  nroot_if.slave bus
);

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_TRY   = 2'd1,
    S_POW   = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] y_q;
  logic [7:0]  n_q;
  logic [15:0] r_q;
  logic [15:0] p_q;
  logic [7:0]  m_q;
  logic [3:0]  k_q;
  logic        fast_q;
  logic        ready_q;
  logic [15:0] out_q;
`ifdef NROOT_ERR_EN
  logic        err_q;
`endif

  logic [15:0] cand;
  logic [31:0] prod;
  logic        bit_done;
  logic        bit_acc;
  logic [15:0] r_step;

  assign cand = r_q | (16'd1 << k_q);
  // Full-width product: anything above y, including overflow past 16 bits, rejects the candidate.
  assign prod = {16'd0, p_q} * {16'd0, cand};

  always_comb begin
    bit_done = 1'b0;
    bit_acc  = 1'b0;
    case (state_q)
      S_TRY: begin
        if (!fast_q && (cand > y_q)) bit_done = 1'b1;
      end
      S_POW: begin
        if (prod > {16'd0, y_q}) begin
          bit_done = 1'b1;
        end else if (m_q == 8'd1) begin
          bit_done = 1'b1;
          bit_acc  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign r_step = bit_acc ? cand : r_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_READY;
      y_q     <= '0;
      n_q     <= '0;
      r_q     <= '0;
      p_q     <= '0;
      m_q     <= '0;
      k_q     <= '0;
      fast_q  <= 1'b0;
      ready_q <= 1'b1;
      out_q   <= '0;
`ifdef NROOT_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_READY: begin
          if (bus.start) begin
            y_q     <= bus.iny;
            n_q     <= bus.inn;
            k_q     <= 4'd15;
            ready_q <= 1'b0;
            state_q <= S_TRY;
            // Trivial degrees and y=0 are resolved here and presented from TRY one edge later.
            if ((bus.inn == 8'd0) || (bus.iny == 16'd0)) begin
              r_q    <= '0;
              fast_q <= 1'b1;
            end else if (bus.inn == 8'd1) begin
              r_q    <= bus.iny;
              fast_q <= 1'b1;
            end else begin
              r_q    <= '0;
              fast_q <= 1'b0;
            end
          end
        end
        S_TRY: begin
          if (fast_q) begin
            out_q   <= r_q;
            ready_q <= 1'b1;
            state_q <= S_READY;
`ifdef NROOT_ERR_EN
            err_q   <= (n_q == 8'd0);
`endif
          end else if (!bit_done) begin
            p_q     <= cand;
            m_q     <= n_q - 8'd1;
            state_q <= S_POW;
          end
        end
        S_POW: begin
          if (!bit_done) begin
            p_q <= prod[15:0];
            m_q <= m_q - 8'd1;
          end
        end
        default: state_q <= S_READY;
      endcase

      if (bit_done) begin
        r_q <= r_step;
        if (k_q == 4'd0) begin
          out_q   <= r_step;
          ready_q <= 1'b1;
          state_q <= S_READY;
`ifdef NROOT_ERR_EN
          err_q   <= 1'b0;
`endif
        end else begin
          k_q     <= k_q - 4'd1;
          state_q <= S_TRY;
        end
      end
    end
  end

  assign bus.ready     = ready_q;
  assign bus.out       = out_q;
  assign bus.dbg_state = state_q;
`ifdef NROOT_ERR_EN
  assign bus.err       = err_q;
`endif

endmodule
